div: RTL



---
 rtl/div.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/div.sv
`default_nettype none
// ============================================================================
// Module   : div
// Brief    : Radix-2 restoring 32-bit divider for DIV/DIVU, one quotient bit
//            per cycle; returns {remainder, quotient} with a ready handshake.
// Revision : 1.0
// ============================================================================
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      S_DIV_FREE    = 2'b00,
      S_DIV_BY_ZERO = 2'b01,
      S_DIV_ON      = 2'b10,
      S_DIV_END     = 2'b11
   } state_t;

   localparam logic [5:0] c_LAST_CNT = 6'd32;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [64:0] r_dividend;
   logic [31:0] r_divisor;
   logic [5:0]  r_cnt;
   logic        r_signed;
   logic        r_op1_neg;
   logic        r_op2_neg;

   logic        w_accept;
   logic        w_div_zero;
   logic        w_cnt_done;
   logic [31:0] w_op1_abs;
   logic [31:0] w_op2_abs;
   logic [32:0] w_tmp;
   logic [31:0] w_quot_fix;
   logic [31:0] w_rem_fix;

   assign w_accept   = start_i && !annul_i;
   assign w_div_zero = (opdata2_i == 32'd0);
   assign w_cnt_done = (r_cnt == c_LAST_CNT);

   assign w_op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   // Trial subtraction; a set borrow bit means the divisor did not fit
   assign w_tmp = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

   assign w_quot_fix = (r_signed && (r_op1_neg ^ r_op2_neg)) ? (~r_dividend[31:0] + 32'd1)
                                                             : r_dividend[31:0];
   assign w_rem_fix  = (r_signed && r_op1_neg) ? (~r_dividend[64:33] + 32'd1)
                                               : r_dividend[64:33];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_DIV_FREE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_DIV_FREE: begin
            if (w_accept) begin
               w_state_nxt = w_div_zero ? S_DIV_BY_ZERO : S_DIV_ON;
            end
         end
         S_DIV_BY_ZERO: begin
            w_state_nxt = S_DIV_END;
         end
         S_DIV_ON: begin
            if (annul_i) begin
               w_state_nxt = S_DIV_FREE;
            end else if (w_cnt_done) begin
               w_state_nxt = S_DIV_END;
            end
         end
         S_DIV_END: begin
            if (!start_i) begin
               w_state_nxt = S_DIV_FREE;
            end
         end
         default: w_state_nxt = S_DIV_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dividend <= 65'd0;
         r_divisor  <= 32'd0;
         r_cnt      <= 6'd0;
         r_signed   <= 1'b0;
         r_op1_neg  <= 1'b0;
         r_op2_neg  <= 1'b0;
         ready_o    <= 1'b0;
         result_o   <= 64'd0;
      end else begin
         case (r_state)
            S_DIV_FREE: begin
               ready_o  <= 1'b0;
               result_o <= 64'd0;
               if (w_accept && !w_div_zero) begin
                  r_dividend <= {32'd0, w_op1_abs, 1'b0};
                  r_divisor  <= w_op2_abs;
                  r_cnt      <= 6'd0;
                  r_signed   <= signed_div_i;
                  r_op1_neg  <= opdata1_i[31];
                  r_op2_neg  <= opdata2_i[31];
               end
            end
            S_DIV_BY_ZERO: begin
               r_dividend <= 65'd0;
            end
            S_DIV_ON: begin
               if (annul_i) begin
                  ready_o  <= 1'b0;
                  result_o <= 64'd0;
                  r_cnt    <= 6'd0;
               end else if (!w_cnt_done) begin
                  if (w_tmp[32]) begin
                     r_dividend <= {r_dividend[63:0], 1'b0};
                  end else begin
                     r_dividend <= {w_tmp[31:0], r_dividend[31:0], 1'b1};
                  end
                  r_cnt <= r_cnt + 6'd1;
               end else begin
                  // Magnitudes are done; restore signs (remainder follows dividend)
                  r_dividend <= {w_rem_fix, r_dividend[32], w_quot_fix};
                  r_cnt      <= 6'd0;
               end
            end
            S_DIV_END: begin
               if (start_i) begin
                  result_o <= {r_dividend[64:33], r_dividend[31:0]};
                  ready_o  <= 1'b1;
               end else begin
                  result_o <= 64'd0;
                  ready_o  <= 1'b0;
               end
            end
            default: begin
               ready_o  <= 1'b0;
               result_o <= 64'd0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
